// File: rtl/virtio_req_arbiter.sv
// virtio_req_arbiter
//   Round-robin arbiter that hands the micro-controller to one of four virtio
//   requesters (console, disk, keyboard, mouse) at a time. Request pulses are
//   captured into sticky pending bits. A grant latches the winner's id and
//   queue select and drives that requester's mode code. The service ends on
//   w_done or on a BUSY-cycle timeout. A timeout sets a sticky error bit for
//   the requester that was being served.
//
// Ports
//   CLK        : clock
//   RST        : synchronous active-high reset
//   w_en       : arbitration enable (gates new grants only)
//   w_req      : per-requester request pulses
//   w_qsel_in  : packed 32-bit queue selects, id0 in [31:0]
//   w_done     : completion pulse (honoured only in BUSY)
//   w_mode     : micro-controller mode code
//   w_start    : one-cycle pulse during GRANT
//   w_gnt_id   : id being served
//   w_qsel     : queue select latched at grant
//   w_pending  : sticky pending-request bits
//   w_err      : sticky per-requester timeout flags
//   w_busy     : high while the FSM is not IDLE
module virtio_req_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter logic [11:0] MODE_MAP = 12'o4321,
  parameter logic [2:0]  MODE_CPU = 3'd0,
  parameter logic [23:0] TIMEOUT  = 24'd1000000
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   w_en,
  input  logic [N_REQ-1:0]       w_req,
  input  logic [32*N_REQ-1:0]    w_qsel_in,
  input  logic                   w_done,
  output logic [2:0]             w_mode,
  output logic                   w_start,
  output logic [1:0]             w_gnt_id,
  output logic [31:0]            w_qsel,
  output logic [N_REQ-1:0]       w_pending,
  output logic [N_REQ-1:0]       w_err,
  output logic                   w_busy
);

  typedef enum logic [1:0] {IDLE, GRANT, BUSY, RELEASE} state_t;

  state_t             state, state_nxt;
  logic [1:0]         last_id;
  logic [23:0]        busy_cnt;

  logic               win_vld;
  logic [1:0]         win_id;
  logic [1:0]         scan_idx;
  logic [31:0]        win_qsel;
  logic [1:0]         gnt_nxt;
  logic [2:0]         mode_nxt;
  logic [N_REQ-1:0]   clr;
  logic               timeout_hit;

  // Round-robin scan starting just above the last served id.
  always_comb begin
    win_vld  = 1'b0;
    win_id   = '0;
    scan_idx = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      scan_idx = last_id + 2'(k + 1);
      if (!win_vld && w_pending[scan_idx]) begin
        win_vld = 1'b1;
        win_id  = scan_idx;
      end
    end
  end

  always_comb begin
    win_qsel = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (win_id == 2'(k)) win_qsel = w_qsel_in[32*k +: 32];
    end
  end

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = w_gnt_id;
    clr         = '0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (w_en && win_vld) begin
          state_nxt   = GRANT;
          gnt_nxt     = win_id;
          clr[win_id] = 1'b1;
        end
      end
      GRANT:   state_nxt = BUSY;
      BUSY: begin
        if (w_done) begin
          state_nxt = RELEASE;
        end else if (busy_cnt == TIMEOUT - 24'd1) begin
          state_nxt   = RELEASE;
          timeout_hit = 1'b1;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mode_nxt = MODE_CPU;
    for (int unsigned k = 0; k < 4; k++) begin
      if (gnt_nxt == 2'(k)) mode_nxt = MODE_MAP[3*k +: 3];
    end
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe in the same cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      w_pending <= '0;
      w_err     <= '0;
      last_id   <= 2'd3;
      busy_cnt  <= '0;
      w_mode    <= MODE_CPU;
      w_start   <= 1'b0;
      w_gnt_id  <= '0;
      w_qsel    <= '0;
      w_busy    <= 1'b0;
    end else begin
      state     <= state_nxt;
      // A new pulse on the bit being cleared wins over the clear.
      w_pending <= (w_pending & ~clr) | w_req;
      w_gnt_id  <= gnt_nxt;
      if (state == IDLE && state_nxt == GRANT) w_qsel <= win_qsel;
      if (state_nxt == GRANT) begin
        busy_cnt <= '0;
      end else if (state == BUSY && state_nxt == BUSY && busy_cnt != '1) begin
        busy_cnt <= busy_cnt + 24'd1;
      end
      if (timeout_hit) w_err[w_gnt_id] <= 1'b1;
      if (state == RELEASE) last_id <= w_gnt_id;
      w_start <= (state_nxt == GRANT);
      w_busy  <= (state_nxt != IDLE);
      w_mode  <= (state_nxt == GRANT || state_nxt == BUSY) ? mode_nxt : MODE_CPU;
    end
  end

endmodule
